nexus_bucket_scheduler: RTL and testbench
=========================================

Name: nexus_bucket_scheduler

Overview:
- Controller that sequences the two-level bucket bitset for the Nexus PIFO.
- Keeps a per-bucket element count and arbitrates enqueue (push) and dequeue (pop) requesters onto the bitset's single set/clear port.
- Returns the best bucket on each pop and clears bitset bits only when a bucket drains to empty.
- Also provides a sequenced flush that empties every bucket.

Parameters:
- BUCKETS, 256: number of buckets; must match the bitset.
- CNT_W, 8: width of each per-bucket element counter.
- IDX_W, $clog2(BUCKETS): bucket index width.

Ports:
- i_clk  in  1  clock.
- i_arst  in  1  reset; asynchronous, active-high.
- i_push_valid  in  1  push request.
- i_push_bucket  in  IDX_W  target bucket of the push.
- o_push_ready  out  1  push accepted this cycle when valid&ready.
- i_pop_valid  in  1  pop request.
- o_pop_ready  out  1  pop accepted this cycle when valid&ready.
- o_pop_resp_valid  out  1  one-cycle pulse; popped bucket available.
- o_pop_bucket  out  IDX_W  bucket index served by the pop.
- i_flush  in  1  single-cycle pulse; start a flush.
- o_busy  out  1  flush in progress.
- o_bs_set_valid  out  1  to bitset: mark o_bs_bucket_idx non-empty.
- o_bs_clear_valid  out  1  to bitset: mark o_bs_bucket_idx empty.
- o_bs_bucket_idx  out  IDX_W  to bitset: bucket index for set/clear.
- i_bs_valid  in  1  from bitset: any bucket non-empty.
- i_bs_best_idx  in  IDX_W  from bitset: lowest-index non-empty bucket.

Behaviour:
- Reset (async, i_arst=1): all counters 0, state IDLE, last_grant=PUSH.
  - Outputs: o_pop_resp_valid=0, o_pop_bucket=0, o_busy=0, o_bs_*=0, o_push_ready=0, o_pop_ready=0.
  - Reset mid-flush aborts the flush immediately.
- FSM states: IDLE, FLUSH.
- IDLE eligibility:
  - push_ok = i_push_valid & (cnt[i_push_bucket] != 2^CNT_W-1). A full bucket never gets ready.
  - pop_ok = i_pop_valid & i_bs_valid.
- IDLE arbitration (combinational ready):
  - Only one eligible: grant it.
  - Both eligible: grant the opposite of last_grant (alternating). last_grant updates on every grant.
  - Ready is 0 for the loser, in FLUSH, and in the cycle i_flush is high.
- Push grant (same cycle):
  - cnt[b] increments at the clock edge.
  - If cnt[b] was 0: o_bs_set_valid=1, o_bs_bucket_idx=b.
- Pop grant (same cycle):
  - b = i_bs_best_idx; cnt[b] decrements at the edge.
  - If cnt[b] was 1: o_bs_clear_valid=1, o_bs_bucket_idx=b.
  - Next cycle: o_pop_resp_valid=1, o_pop_bucket=b (registered, latency 1).
  - o_pop_bucket holds its value until the next pop response.
- The bitset updates on the same edge as the counters, so i_bs_* is consistent in the next cycle. Back-to-back grants every cycle are legal.
- At most one of o_bs_set_valid / o_bs_clear_valid is high in any cycle.
- Pop with i_bs_valid=0: never granted. No underflow is possible.
- i_flush in IDLE:
  - No grant that cycle. Next state FLUSH, walk index w=0, o_busy=1.
- FLUSH, each cycle:
  - cnt[w]=0.
  - If cnt[w] was non-zero: o_bs_clear_valid=1, o_bs_bucket_idx=w.
  - w increments.
  - After w=BUCKETS-1, return to IDLE. o_busy falls on the cycle IDLE is re-entered.
  - Flush takes exactly BUCKETS cycles.
- i_flush asserted during FLUSH: ignored.
- A pop response pending at flush start is still delivered.

Optional Feature:
- Macro: NEXUS_SCHED_STATS_EN.
- Defined:
  - Adds output o_total_occ (width IDX_W+CNT_W): total queued elements.
  - Increments on push grant, decrements on pop grant, zeroed by flush start and by reset.
  - Adds sticky output o_push_stall: set when i_push_valid=1 for a full bucket; cleared by reset or flush.
- Undefined: neither port exists; there is no counter logic.

Test Plan:
- Push buckets 5, 5, 3 on consecutive cycles:
  - o_bs_set_valid pulses for 5 (first push only) and 3.
  - Next pop returns o_pop_bucket=3 one cycle after grant, with o_bs_clear_valid for idx 3.
- Continuing from the previous scenario, two pops:
  - Both return bucket 5.
  - o_bs_clear_valid asserts only on the second pop.
  - Afterwards i_bs_valid=0 and o_pop_ready=0.
- Push and pop valid together for 4 cycles with bucket 7 non-empty:
  - Grants alternate POP, PUSH, POP, PUSH (last_grant=PUSH after reset).
  - Count stays consistent.
- Push bucket 9 255 times (CNT_W=8), then push again:
  - o_push_ready=0.
  - STATS build: o_push_stall=1 and o_total_occ=255.
- Buckets 0, 100, 255 non-empty; pulse i_flush:
  - o_busy high for 256 cycles.
  - Exactly 3 clear pulses, at idx 0, 100, 255.
  - No ready during flush; afterwards all counters are 0.
- Assert i_arst mid-flush at w=50:
  - All outputs 0 immediately; o_busy=0.
  - After release, a push to bucket 2 gives o_bs_set_valid, because its count is 0.

Source files
------------

// File: rtl/nexus_bucket_scheduler.sv
// Bucket-count controller for the Nexus PIFO two-level bitset: arbitrates push/pop onto the
// bitset's set/clear port and sequences a full flush. Define NEXUS_SCHED_STATS_EN for occupancy/stall stats.
module nexus_bucket_scheduler #(
  parameter int unsigned BUCKETS = 256,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned IDX_W   = $clog2(BUCKETS)
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic             i_push_valid,
  input  logic [IDX_W-1:0] i_push_bucket,
  output logic             o_push_ready,
  input  logic             i_pop_valid,
  output logic             o_pop_ready,
  output logic             o_pop_resp_valid,
  output logic [IDX_W-1:0] o_pop_bucket,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_bs_set_valid,
  output logic             o_bs_clear_valid,
  output logic [IDX_W-1:0] o_bs_bucket_idx,
  input  logic             i_bs_valid,
  input  logic [IDX_W-1:0] i_bs_best_idx
`ifdef NEXUS_SCHED_STATS_EN
  ,
  output logic [IDX_W+CNT_W-1:0] o_total_occ,
  output logic                   o_push_stall
`endif
);

  typedef enum logic {IDLE, FLUSH} state_e;
  typedef enum logic {GRANT_PUSH, GRANT_POP} grant_e;

  state_e           state;
  grant_e           last_grant;
  logic [IDX_W-1:0] walk;
  logic [CNT_W-1:0] cnt [BUCKETS];

  logic push_full, push_ok, pop_ok, can_grant, grant_push, grant_pop;

  always_comb begin
    push_full  = (cnt[i_push_bucket] == '1);
    push_ok    = i_push_valid & ~push_full;
    pop_ok     = i_pop_valid & i_bs_valid;
    can_grant  = (state == IDLE) & ~i_flush & ~i_arst;
    // On contention the requester that did not win last time goes first.
    grant_push = can_grant & push_ok & (~pop_ok | (last_grant == GRANT_POP));
    grant_pop  = can_grant & pop_ok & (~push_ok | (last_grant == GRANT_PUSH));

    o_bs_set_valid   = 1'b0;
    o_bs_clear_valid = 1'b0;
    o_bs_bucket_idx  = '0;
    if (i_arst) begin
      o_bs_set_valid = 1'b0;
    end else if (state == FLUSH) begin
      o_bs_clear_valid = (cnt[walk] != '0);
      o_bs_bucket_idx  = walk;
    end else if (grant_push) begin
      o_bs_set_valid  = (cnt[i_push_bucket] == '0);
      o_bs_bucket_idx = i_push_bucket;
    end else if (grant_pop) begin
      o_bs_clear_valid = (cnt[i_bs_best_idx] == CNT_W'(1));
      o_bs_bucket_idx  = i_bs_best_idx;
    end
  end

  assign o_push_ready = grant_push;
  assign o_pop_ready  = grant_pop;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state            <= IDLE;
      last_grant       <= GRANT_PUSH;
      walk             <= '0;
      o_busy           <= 1'b0;
      o_pop_resp_valid <= 1'b0;
      o_pop_bucket     <= '0;
      for (int unsigned i = 0; i < BUCKETS; i++) cnt[IDX_W'(i)] <= '0;
    end else begin
      o_pop_resp_valid <= grant_pop;
      case (state)
        IDLE: begin
          if (i_flush) begin
            state  <= FLUSH;
            walk   <= '0;
            o_busy <= 1'b1;
          end else if (grant_push) begin
            cnt[i_push_bucket] <= cnt[i_push_bucket] + CNT_W'(1);
            last_grant         <= GRANT_PUSH;
          end else if (grant_pop) begin
            cnt[i_bs_best_idx] <= cnt[i_bs_best_idx] - CNT_W'(1);
            last_grant         <= GRANT_POP;
            o_pop_bucket       <= i_bs_best_idx;
          end
        end
        FLUSH: begin
          cnt[walk] <= '0;
          walk      <= walk + IDX_W'(1);
          if (walk == IDX_W'(BUCKETS - 1)) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NEXUS_SCHED_STATS_EN
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      o_total_occ  <= '0;
      o_push_stall <= 1'b0;
    end else if (state == IDLE && i_flush) begin
      o_total_occ  <= '0;
      o_push_stall <= 1'b0;
    end else begin
      if (grant_push)     o_total_occ <= o_total_occ + (IDX_W+CNT_W)'(1);
      else if (grant_pop) o_total_occ <= o_total_occ - (IDX_W+CNT_W)'(1);
      if (state == IDLE && i_push_valid && push_full) o_push_stall <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_nexus_bucket_scheduler.sv
// Scoreboard bench for nexus_bucket_scheduler: a behavioural bitset closes the loop,
// expected bitset strobes and pop responses are queued by the stimulus and checked by a monitor.
module tb_nexus_bucket_scheduler;
  localparam int unsigned BUCKETS = 256;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned IDX_W   = 8;

  logic             clk = 1'b0;
  logic             arst;
  logic             push_valid, pop_valid, flush;
  logic [IDX_W-1:0] push_bucket;
  logic             push_ready, pop_ready, pop_resp_valid, busy;
  logic [IDX_W-1:0] pop_bucket;
  logic             bs_set_valid, bs_clear_valid, bs_valid;
  logic [IDX_W-1:0] bs_bucket_idx, bs_best_idx;
`ifdef NEXUS_SCHED_STATS_EN
  logic [IDX_W+CNT_W-1:0] total_occ;
  logic                   push_stall;
`endif

  always #5 clk = ~clk;

  nexus_bucket_scheduler #(.BUCKETS(BUCKETS), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .i_clk(clk), .i_arst(arst),
    .i_push_valid(push_valid), .i_push_bucket(push_bucket), .o_push_ready(push_ready),
    .i_pop_valid(pop_valid), .o_pop_ready(pop_ready),
    .o_pop_resp_valid(pop_resp_valid), .o_pop_bucket(pop_bucket),
    .i_flush(flush), .o_busy(busy),
    .o_bs_set_valid(bs_set_valid), .o_bs_clear_valid(bs_clear_valid),
    .o_bs_bucket_idx(bs_bucket_idx),
    .i_bs_valid(bs_valid), .i_bs_best_idx(bs_best_idx)
`ifdef NEXUS_SCHED_STATS_EN
    , .o_total_occ(total_occ), .o_push_stall(push_stall)
`endif
  );

  // Behavioural two-level bitset: updates on the same edge as the scheduler's counters.
  logic [BUCKETS-1:0] bits;
  always @(posedge clk or posedge arst) begin
    if (arst) bits <= '0;
    else if (bs_set_valid) bits[bs_bucket_idx] <= 1'b1;
    else if (bs_clear_valid) bits[bs_bucket_idx] <= 1'b0;
  end
  always_comb begin
    bs_valid    = |bits;
    bs_best_idx = '0;
    for (int i = BUCKETS - 1; i >= 0; i--) if (bits[i]) bs_best_idx = IDX_W'(i);
  end

  typedef struct {bit clr; logic [IDX_W-1:0] idx;} bs_ev_t;
  bs_ev_t           bs_q[$];
  logic [IDX_W-1:0] pop_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic exp_bs(input bit clr, input int idx);
    bs_ev_t e;
    e.clr = clr;
    e.idx = idx[IDX_W-1:0];
    bs_q.push_back(e);
  endtask

  // Monitor: every bitset strobe and pop response must match the next queued expectation.
  always @(negedge clk) begin
    if (!arst) begin
      chk("bs_exclusive", {31'd0, bs_set_valid & bs_clear_valid}, 32'd0);
      if (bs_set_valid || bs_clear_valid) begin
        if (bs_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL bs_unexpected actual=set%0d/clr%0d idx=%0d required=none",
                   bs_set_valid, bs_clear_valid, bs_bucket_idx);
        end else begin
          bs_ev_t e;
          e = bs_q.pop_front();
          chk("bs_kind_clear", {31'd0, bs_clear_valid}, {31'd0, e.clr});
          chk("bs_idx", {24'd0, bs_bucket_idx}, {24'd0, e.idx});
        end
      end
      if (pop_resp_valid) begin
        if (pop_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pop_unexpected actual=%0d required=none", pop_bucket);
        end else begin
          logic [IDX_W-1:0] eb;
          eb = pop_q.pop_front();
          chk("pop_bucket", {24'd0, pop_bucket}, {24'd0, eb});
        end
      end
    end
  end

  task automatic step(input logic pv, input int pb, input logic ov, input logic fl,
                      input logic e_push, input logic e_pop, input logic e_busy, input string nm);
    push_valid  = pv;
    push_bucket = pb[IDX_W-1:0];
    pop_valid   = ov;
    flush       = fl;
    @(negedge clk);
    chk({nm, "_push_ready"}, {31'd0, push_ready}, {31'd0, e_push});
    chk({nm, "_pop_ready"}, {31'd0, pop_ready}, {31'd0, e_pop});
    chk({nm, "_busy"}, {31'd0, busy}, {31'd0, e_busy});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_push_ready"}, {31'd0, push_ready}, 32'd0);
    chk({nm, "_pop_ready"}, {31'd0, pop_ready}, 32'd0);
    chk({nm, "_resp_valid"}, {31'd0, pop_resp_valid}, 32'd0);
    chk({nm, "_pop_bucket"}, {24'd0, pop_bucket}, 32'd0);
    chk({nm, "_bs_set"}, {31'd0, bs_set_valid}, 32'd0);
    chk({nm, "_bs_clear"}, {31'd0, bs_clear_valid}, 32'd0);
    chk({nm, "_bs_idx"}, {24'd0, bs_bucket_idx}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    arst = 1'b1; push_valid = 1'b1; push_bucket = 8'd5; pop_valid = 1'b1; flush = 1'b0;
    #2;
    chk_all_zero("reset");
    @(posedge clk); #1;
    arst = 1'b0; push_valid = 1'b0; pop_valid = 1'b0;
    @(posedge clk); #1;

    // Pushes 5, 5, 3 then one pop serves bucket 3.
    exp_bs(0, 5); step(1, 5, 0, 0, 1, 0, 0, "push5a");
    step(1, 5, 0, 0, 1, 0, 0, "push5b");
    exp_bs(0, 3); step(1, 3, 0, 0, 1, 0, 0, "push3");
    exp_bs(1, 3); pop_q.push_back(8'd3); step(0, 0, 1, 0, 0, 1, 0, "pop3");

    // Two pops from bucket 5; only the second clears it.
    pop_q.push_back(8'd5); step(0, 0, 1, 0, 0, 1, 0, "pop5a");
    exp_bs(1, 5); pop_q.push_back(8'd5); step(0, 0, 1, 0, 0, 1, 0, "pop5b");
    step(0, 0, 1, 0, 0, 0, 0, "pop_empty");

    // Alternating arbitration with bucket 7 kept non-empty.
    exp_bs(0, 7); step(1, 7, 0, 0, 1, 0, 0, "push7a");
    step(1, 7, 0, 0, 1, 0, 0, "push7b");
    pop_q.push_back(8'd7); step(1, 7, 1, 0, 0, 1, 0, "arb1_pop");
    step(1, 7, 1, 0, 1, 0, 0, "arb2_push");
    pop_q.push_back(8'd7); step(1, 7, 1, 0, 0, 1, 0, "arb3_pop");
    step(1, 7, 1, 0, 1, 0, 0, "arb4_push");
    pop_q.push_back(8'd7); step(0, 0, 1, 0, 0, 1, 0, "drain7a");
    exp_bs(1, 7); pop_q.push_back(8'd7); step(0, 0, 1, 0, 0, 1, 0, "drain7b");
    step(0, 0, 1, 0, 0, 0, 0, "drained7");

    // Fill bucket 9 to its limit, then one more push is refused.
    exp_bs(0, 9);
    for (int i = 0; i < 255; i++) step(1, 9, 0, 0, 1, 0, 0, "fill9");
    step(1, 9, 0, 0, 0, 0, 0, "push9_full");
`ifdef NEXUS_SCHED_STATS_EN
    chk("stall_set", {31'd0, push_stall}, 32'd1);
    chk("occ_255", {16'd0, total_occ}, 32'd255);
`endif
    for (int i = 0; i < 255; i++) begin
      pop_q.push_back(8'd9);
      if (i == 254) exp_bs(1, 9);
      step(0, 0, 1, 0, 0, 1, 0, "drain9");
    end
`ifdef NEXUS_SCHED_STATS_EN
    chk("occ_drained", {16'd0, total_occ}, 32'd0);
`endif

    // Flush with buckets 0, 100, 255 occupied.
    exp_bs(0, 0);   step(1, 0, 0, 0, 1, 0, 0, "push0");
    exp_bs(0, 100); step(1, 100, 0, 0, 1, 0, 0, "push100");
    exp_bs(0, 255); step(1, 255, 0, 0, 1, 0, 0, "push255");
`ifdef NEXUS_SCHED_STATS_EN
    chk("occ_3", {16'd0, total_occ}, 32'd3);
`endif
    exp_bs(1, 0); exp_bs(1, 100); exp_bs(1, 255);
    step(1, 1, 1, 1, 0, 0, 0, "flush_start");
    for (int i = 0; i < 256; i++) step(1, 1, 1, 1, 0, 0, 1, "flushing");
    step(0, 0, 0, 0, 0, 0, 0, "flush_done");
`ifdef NEXUS_SCHED_STATS_EN
    chk("occ_flushed", {16'd0, total_occ}, 32'd0);
    chk("stall_flushed", {31'd0, push_stall}, 32'd0);
`endif
    exp_bs(0, 0);   step(1, 0, 0, 0, 1, 0, 0, "repush0");
    exp_bs(0, 100); step(1, 100, 0, 0, 1, 0, 0, "repush100");
    exp_bs(0, 255); step(1, 255, 0, 0, 1, 0, 0, "repush255");

    // Reset in the middle of a second flush, at walk index 50.
    exp_bs(1, 0); step(0, 0, 0, 1, 0, 0, 0, "flush2_start");
    for (int i = 0; i < 50; i++) step(0, 0, 0, 0, 0, 0, 1, "flush2");
    push_valid = 1'b1; push_bucket = 8'd2; arst = 1'b1;
    #1;
    chk_all_zero("midflush_reset");
    #2;
    arst = 1'b0; push_valid = 1'b0;
    @(posedge clk); #1;
    exp_bs(0, 2);   step(1, 2, 0, 0, 1, 0, 0, "post_reset_push2");
    exp_bs(0, 100); step(1, 100, 0, 0, 1, 0, 0, "post_reset_push100");
    step(0, 0, 0, 0, 0, 0, 0, "idle_end");
    step(0, 0, 0, 0, 0, 0, 0, "idle_end");

    chk("bs_queue_empty", bs_q.size(), 32'd0);
    chk("pop_queue_empty", pop_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
